rom_loader: RTL and testbench

Boot-time instruction-memory writer for the SoC: the write-side counterpart of the core's instruction fetch path. It accepts a framed byte stream (length header followed by little-endian instruction words), drives the instruction ROM write port with one word per write pulse, and holds the core in reset while the load is in progress. It sits between a host byte source (UART RX or debug bridge) and the `w_en_i`/`w_addr_i`/`w_data_i` port of `rom`. Its `core_rst_n_o` output is ANDed into the core's `rst_n`.

---
 rtl/rom_loader.sv | 158 +++++++++++++++
 tb/tb_rom_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// Framed byte-stream writer for the instruction ROM; holds the core in reset while loading.
// Optional trailing checksum byte enabled by ROM_LOADER_CHKSUM_EN.
module rom_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_req_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        w_en_o,
  output logic [31:0] w_addr_o,
  output logic [31:0] w_data_o,
  output logic        core_rst_n_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
`ifdef ROM_LOADER_CHKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

`ifdef ROM_LOADER_CHKSUM_EN
  localparam state_t S_FIN = S_CHK;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t      state, state_n;
  logic [1:0]  bcnt;
  logic [31:0] len, wbuf, k;
  logic [31:0] shift_n;
  logic        accept, start, rdy_n, busy_n;
`ifdef ROM_LOADER_CHKSUM_EN
  logic [7:0]  sum;
`endif

  // Both len and the data word assemble LSB-first by shifting in at the top.
  assign accept = byte_valid_i && byte_ready_o;

  always_comb begin
    state_n = state;
    start   = 1'b0;
    shift_n = {byte_data_i, (state == S_LEN) ? len[31:8] : wbuf[31:8]};
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (load_req_i) begin
          state_n = S_LEN;
          start   = 1'b1;
        end
      end
      S_LEN: begin
        if (accept && bcnt == 2'd3) begin
          if (shift_n > 32'(MAX_WORDS)) state_n = S_ERR;
          else if (shift_n == 32'd0)    state_n = S_FIN;
          else                          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && bcnt == 2'd3) state_n = S_WRITE;
      end
      S_WRITE: begin
        state_n = (k + 32'd1 == len) ? S_FIN : S_DATA;
      end
`ifdef ROM_LOADER_CHKSUM_EN
      S_CHK: begin
        if (accept) state_n = (byte_data_i == sum) ? S_DONE : S_ERR;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    rdy_n  = 1'b0;
    busy_n = 1'b0;
    unique case (1'b1)
      state_n == S_LEN,
      state_n == S_DATA: begin
        rdy_n  = 1'b1;
        busy_n = 1'b1;
      end
`ifdef ROM_LOADER_CHKSUM_EN
      state_n == S_CHK: begin
        rdy_n  = 1'b1;
        busy_n = 1'b1;
      end
`endif
      state_n == S_WRITE: busy_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_ready_o <= 1'b0;
      w_en_o       <= 1'b0;
      w_addr_o     <= 32'd0;
      w_data_o     <= 32'd0;
      core_rst_n_o <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      bcnt         <= 2'd0;
      len          <= 32'd0;
      wbuf         <= 32'd0;
      k            <= 32'd0;
`ifdef ROM_LOADER_CHKSUM_EN
      sum          <= 8'd0;
`endif
    end else begin
      byte_ready_o <= rdy_n;
      busy_o       <= busy_n;
      core_rst_n_o <= (state_n == S_IDLE) || (state_n == S_DONE);
      done_o       <= state_n == S_DONE;
      err_o        <= state_n == S_ERR;
      w_en_o       <= state_n == S_WRITE;
      if (state_n == S_WRITE) begin
        w_addr_o <= BASE_ADDR + {k[29:0], 2'b00};
        w_data_o <= shift_n;
      end
      if (start) begin
        bcnt <= 2'd0;
        len  <= 32'd0;
        k    <= 32'd0;
`ifdef ROM_LOADER_CHKSUM_EN
        sum  <= 8'd0;
`endif
      end
      if (accept) begin
        bcnt <= bcnt + 2'd1;
        if (state == S_LEN)  len  <= shift_n;
        if (state == S_DATA) wbuf <= shift_n;
`ifdef ROM_LOADER_CHKSUM_EN
        if (state == S_DATA) sum  <= sum + byte_data_i;
`endif
      end
      if (state == S_WRITE) k <= k + 32'd1;
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: table of framed loads plus timing/reset sequences.
// Works with or without ROM_LOADER_CHKSUM_EN defined.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_req = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready, w_en, core_rst_n, busy, done, err;
  logic [31:0] w_addr, w_data;

  rom_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(4096)) dut (
    .clk(clk), .rst_n(rst_n), .load_req_i(load_req),
    .byte_valid_i(byte_valid), .byte_data_i(byte_data),
    .byte_ready_o(byte_ready), .w_en_o(w_en),
    .w_addr_o(w_addr), .w_data_o(w_data),
    .core_rst_n_o(core_rst_n), .busy_o(busy),
    .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];

  always @(negedge clk) begin
    if (w_en) begin
      wa_q.push_back(w_addr);
      wd_q.push_back(w_data);
      wc_q.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) repeat ($urandom_range(0, 3)) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) chk("handshake_timeout", 32'(byte_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic pulse_load();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || err) && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  typedef struct {
    logic [31:0]      hdr;
    int               nw;
    logic [2:0][31:0] w;
    bit               gaps;
    bit               exp_err;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] hdr, input int nw,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input bit gaps, input bit e);
    vec_t v;
    v.hdr = hdr;
    v.nw = nw;
    v.w[0] = w0;
    v.w[1] = w1;
    v.w[2] = w2;
    v.gaps = gaps;
    v.exp_err = e;
    return v;
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    logic [7:0] s;
    int         nexp;
    s = 8'd0;
    clear_mon();
    pulse_load();
    chk($sformatf("v%0d_busy_start", id), 32'(busy), 32'd1);
    chk($sformatf("v%0d_crst_start", id), 32'(core_rst_n), 32'd0);
    chk($sformatf("v%0d_ready_start", id), 32'(byte_ready), 32'd1);
    chk($sformatf("v%0d_done_clr", id), 32'(done), 32'd0);
    chk($sformatf("v%0d_err_clr", id), 32'(err), 32'd0);
    send_word(v.hdr, v.gaps);
    if (v.exp_err) begin
      chk($sformatf("v%0d_err", id), 32'(err), 32'd1);
      chk($sformatf("v%0d_crst_err", id), 32'(core_rst_n), 32'd0);
      chk($sformatf("v%0d_ready_err", id), 32'(byte_ready), 32'd0);
      chk($sformatf("v%0d_busy_err", id), 32'(busy), 32'd0);
    end else begin
`ifndef ROM_LOADER_CHKSUM_EN
      if (v.nw == 0) chk($sformatf("v%0d_zero_done_t1", id), 32'(done), 32'd1);
`endif
      for (int i = 0; i < v.nw; i++) begin
        send_word(v.w[i], v.gaps);
        for (int j = 0; j < 4; j++) s = s + v.w[i][8*j +: 8];
      end
`ifdef ROM_LOADER_CHKSUM_EN
      send_byte(s, v.gaps);
`endif
      wait_end();
      chk($sformatf("v%0d_done", id), 32'(done), 32'd1);
      chk($sformatf("v%0d_err0", id), 32'(err), 32'd0);
      chk($sformatf("v%0d_crst_done", id), 32'(core_rst_n), 32'd1);
      chk($sformatf("v%0d_busy_done", id), 32'(busy), 32'd0);
    end
    repeat (3) @(negedge clk);
    nexp = v.exp_err ? 0 : v.nw;
    chk($sformatf("v%0d_nwrites", id), 32'(wa_q.size()), 32'(nexp));
    for (int i = 0; i < nexp && i < wa_q.size(); i++) begin
      chk($sformatf("v%0d_addr%0d", id, i), wa_q[i], 32'(4 * i));
      chk($sformatf("v%0d_data%0d", id, i), wd_q[i], v.w[i]);
      if (i > 0)
        chk($sformatf("v%0d_space%0d", id, i), 32'(wc_q[i] - wc_q[i-1] >= 5), 32'd1);
    end
  endtask

  vec_t tv[7];

  initial begin
    tv[0] = mk(32'd2, 2, 32'h13, 32'h6F, 32'h0, 1'b0, 1'b0);
    tv[1] = mk(32'd0, 0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tv[2] = mk(32'h1001, 0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    tv[3] = mk(32'd3, 3, 32'hDEADBEEF, 32'h00112233, 32'h80000001, 1'b0, 1'b0);
    tv[4] = mk(32'd3, 3, 32'hDEADBEEF, 32'h00112233, 32'h80000001, 1'b1, 1'b0);
    tv[5] = mk(32'hFFFFFFFF, 0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    tv[6] = mk(32'd1, 1, 32'h04030201, 32'h0, 32'h0, 1'b1, 1'b0);

    // Reset state
    #12;
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_wen", 32'(w_en), 32'd0);
    chk("rst_addr", w_addr, 32'd0);
    chk("rst_data", w_data, 32'd0);
    chk("rst_crst", 32'(core_rst_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i, tv[i]);

    // Write-pulse timing after the 4th data byte
    clear_mon();
    pulse_load();
    send_word(32'd2, 1'b0);
    send_word(32'h13, 1'b0);
    chk("t_wen_hi", 32'(w_en), 32'd1);
    chk("t_ready_lo", 32'(byte_ready), 32'd0);
    chk("t_addr0", w_addr, 32'h0);
    chk("t_data0", w_data, 32'h13);
    @(negedge clk);
    chk("t_wen_lo", 32'(w_en), 32'd0);
    chk("t_ready_back", 32'(byte_ready), 32'd1);
    chk("t_addr_hold", w_addr, 32'h0);
    chk("t_data_hold", w_data, 32'h13);
    send_word(32'h6F, 1'b0);
    chk("t_addr1", w_addr, 32'h4);
    chk("t_data1", w_data, 32'h6F);
`ifndef ROM_LOADER_CHKSUM_EN
    @(negedge clk);
    chk("t_done_t1", 32'(done), 32'd1);
    chk("t_crst_t1", 32'(core_rst_n), 32'd1);
`else
    send_byte(8'h82, 1'b0);
    chk("t_done_chk", 32'(done), 32'd1);
`endif

    // Reset mid-load after 6 data bytes
    clear_mon();
    pulse_load();
    send_word(32'd3, 1'b0);
    send_word(32'hAABBCCDD, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    rst_n = 1'b0;
    #1;
    chk("mr_ready", 32'(byte_ready), 32'd0);
    chk("mr_wen", 32'(w_en), 32'd0);
    chk("mr_addr", w_addr, 32'd0);
    chk("mr_data", w_data, 32'd0);
    chk("mr_crst", 32'(core_rst_n), 32'd1);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    byte_valid = 1'b0;
    chk("mr_nwrites", 32'(wa_q.size()), 32'd1);
    chk("mr_crst_after", 32'(core_rst_n), 32'd1);
    chk("mr_busy_after", 32'(busy), 32'd0);

`ifdef ROM_LOADER_CHKSUM_EN
    // Bad checksum: word is written, then the load is rejected
    clear_mon();
    pulse_load();
    send_word(32'd1, 1'b0);
    send_word(32'h04030201, 1'b0);
    send_byte(8'h0B, 1'b0);
    wait_end();
    chk("ck_err", 32'(err), 32'd1);
    chk("ck_done", 32'(done), 32'd0);
    chk("ck_crst", 32'(core_rst_n), 32'd0);
    chk("ck_nwrites", 32'(wa_q.size()), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
